verin_pwm_gen: RTL

- Downstream consumer of the 16-bit duty PIO output in the actuator (vérin) control path.
- Generates a PWM drive signal and a direction signal for the H-bridge from the processor-written duty, period and control values.
- Duty and period are double-buffered so that software writes take effect only on a PWM period boundary, giving glitch-free output.
- Sits between the SOPC PIO outputs and the top-level actuator pins.

---
 rtl/verin_pwm_gen.sv | 116 +++++++++++
 1 files changed

// File: rtl/verin_pwm_gen.sv
// PWM and direction generator for the actuator H-bridge.
// Duty, period and direction are shadowed and only reloaded on a period boundary.
//
// state | meaning
// IDLE  | outputs low, waiting for enable with a non-zero period
// RUN   | prescaler and period counter running, pwm_out active
module verin_pwm_gen #(
    parameter int PRESC_W   = 8,
    parameter int PRESC_DIV = 50,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sens,
    input  logic [CNT_W-1:0] duty,
    input  logic [CNT_W-1:0] period,
    output logic             pwm_out,
    output logic             dir_out,
    output logic             period_tick,
    output logic             running
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);

    state_t             state, state_nxt;
    logic [PRESC_W-1:0] presc, presc_nxt;
    logic [CNT_W-1:0]   counter, counter_nxt;
    logic [CNT_W-1:0]   duty_sh, duty_sh_nxt;
    logic [CNT_W-1:0]   period_sh, period_sh_nxt;
    logic               dir_nxt;
    logic               pwm_nxt;
    logic               tick;
    logic               boundary;

    assign tick     = (state == RUN) && (presc == PRESC_LAST);
    assign boundary = tick && (counter == (period_sh - CNT_W'(1)));

    // Combinational so the pulse coincides with the clk that wraps the counter.
    assign period_tick = boundary;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            counter   <= '0;
            duty_sh   <= '0;
            period_sh <= '0;
            dir_out   <= 1'b0;
            pwm_out   <= 1'b0;
            running   <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            counter   <= counter_nxt;
            duty_sh   <= duty_sh_nxt;
            period_sh <= period_sh_nxt;
            dir_out   <= dir_nxt;
            pwm_out   <= pwm_nxt;
            running   <= (state_nxt == RUN);
        end
    end

    always_comb begin
        state_nxt     = state;
        presc_nxt     = presc;
        counter_nxt   = counter;
        duty_sh_nxt   = duty_sh;
        period_sh_nxt = period_sh;
        dir_nxt       = dir_out;

        case (state)
            IDLE: begin
                presc_nxt = '0;
                if (enable && (period != '0)) begin
                    state_nxt     = RUN;
                    duty_sh_nxt   = duty;
                    period_sh_nxt = period;
                    dir_nxt       = sens;
                    counter_nxt   = '0;
                end
            end
            RUN: begin
                presc_nxt = tick ? '0 : presc + PRESC_W'(1);
                if (boundary) begin
                    counter_nxt   = '0;
                    duty_sh_nxt   = duty;
                    period_sh_nxt = period;
                    // Direction may only flip when the coming period has no high phase.
                    if (duty == '0)
                        dir_nxt = sens;
                    if (!enable || (period == '0))
                        state_nxt = IDLE;
                end else if (tick) begin
                    counter_nxt = counter + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt == IDLE) begin
            dir_nxt   = 1'b0;
            presc_nxt = '0;
        end

        pwm_nxt = (state_nxt == RUN) && (counter_nxt < duty_sh_nxt);
    end

endmodule
